// File: rtl/nios_adc_debug_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : nios_adc_debug_pkg                                           |
// | Brief    : Shared widths, command record and action-bit helper for the  |
// |            sysclk-side JTAG debug command receiver.                     |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
package nios_adc_debug_pkg;

  localparam int SR_W_DEF = 38;
  localparam int IR_W_DEF = 2;

  // One queued debug command at the default widths: captured IR plus data.
  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [SR_W_DEF-1:0] data;
  } debug_cmd_t;

  // The action (take / no-take) flag is the top bit of the data register.
  function automatic int act_bit_pos(input int sr_w);
    return sr_w - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_adc_debug_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : nios_adc_debug_sync_edge                                     |
// | Brief    : 3-flop synchroniser preset to 1 on reset, with a rising-edge |
// |            pulse taken from the 2nd/3rd stage.                          |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
module nios_adc_debug_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchroniser chain; presetting to 1 means a strobe already high at
  // reset release cannot look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o = s2_q & ~s3_q;

endmodule
`default_nettype wire

// File: rtl/nios_adc_debug_cmd_sysclk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : nios_adc_debug_cmd_sysclk                                    |
// | Brief    : Sysclk-side receiver for JTAG debug-slave commands. Captures |
// |            {IR, DR} on a synchronised Update-DR into a command FIFO and |
// |            presents it through valid/ready with take/no-take decode.    |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
module nios_adc_debug_cmd_sysclk
  import nios_adc_debug_pkg::*;
#(
  parameter int SR_W  = SR_W_DEF,
  parameter int IR_W  = IR_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [SR_W-1:0]          sr,
  input  logic                     act_ready,
  input  logic                     clr_overflow,
  output logic                     act_valid,
  output logic [SR_W-1:0]          jdo,
  output logic [IR_W-1:0]          act_ch,
  output logic [(2**IR_W)-1:0]     act_take,
  output logic [(2**IR_W)-1:0]     act_no_take,
  output logic                     ir_update,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int NUM_CH = 2**IR_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int CMD_W  = IR_W + SR_W;
  localparam int ACT    = act_bit_pos(SR_W);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic udr_edge;
  logic uir_edge;

  nios_adc_debug_sync_edge u_sync_udr (
    .clk     (clk),
    .reset   (reset),
    .async_i (vs_udr),
    .edge_o  (udr_edge)
  );

  nios_adc_debug_sync_edge u_sync_uir (
    .clk     (clk),
    .reset   (reset),
    .async_i (vs_uir),
    .edge_o  (uir_edge)
  );

  // FIFO storage and pointers; pointer MSB separates full from empty.
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             ovf_set;
  logic             ir_update_q;
  logic             overflow_q;

  logic             empty;
  logic             full;
  logic             pop;
  logic [CMD_W-1:0] head;

  assign level = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (level == FULL_LVL);
  assign pop   = ~empty & act_ready;
  assign head  = mem_q[rd_q[AW-1:0]];

  // Pointer next-state: a UIR edge flushes first, and a same-cycle UDR
  // edge then lands as the sole entry; a full push only survives a pop.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    wr_en   = 1'b0;
    wr_addr = wr_q[AW-1:0];
    ovf_set = 1'b0;
    if (uir_edge) begin
      rd_d    = '0;
      wr_d    = '0;
      wr_addr = '0;
      if (udr_edge) begin
        wr_en = 1'b1;
        wr_d  = PTR_ONE;
      end
    end else begin
      if (pop) begin
        rd_d = rd_q + PTR_ONE;
      end
      if (udr_edge) begin
        if (!full || pop) begin
          wr_en = 1'b1;
          wr_d  = wr_q + PTR_ONE;
        end else begin
          ovf_set = 1'b1;
        end
      end
    end
  end

  // Pointer, strobe-pulse and sticky-overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q        <= '0;
      rd_q        <= '0;
      ir_update_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ir_update_q <= uir_edge;
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Command storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= {ir_in, sr};
    end
  end

  assign ir_update = ir_update_q;
  assign overflow  = overflow_q;
  assign act_valid = ~empty;

  // Head presentation is gated so idle/reset outputs read as zero.
  always_comb begin
    jdo         = '0;
    act_ch      = '0;
    act_take    = '0;
    act_no_take = '0;
    if (act_valid) begin
      jdo    = head[SR_W-1:0];
      act_ch = head[CMD_W-1:SR_W];
      if (head[ACT]) begin
        act_take    = {{(NUM_CH-1){1'b0}}, 1'b1} << act_ch;
      end else begin
        act_no_take = {{(NUM_CH-1){1'b0}}, 1'b1} << act_ch;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_adc_debug_cmd_sysclk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_nios_adc_debug_cmd_sysclk                                 |
// | Brief    : Directed bench with an expected-command queue for the sysclk |
// |            debug command receiver.                                      |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
module tb_nios_adc_debug_cmd_sysclk;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int DEPTH = 4;
  localparam int NCH   = 2**IR_W;

  typedef struct packed {
    logic [IR_W-1:0] ch;
    logic [SR_W-1:0] d;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   vs_udr;
  logic                   vs_uir;
  logic [IR_W-1:0]        ir_in;
  logic [SR_W-1:0]        sr;
  logic                   act_ready;
  logic                   clr_overflow;
  logic                   act_valid;
  logic [SR_W-1:0]        jdo;
  logic [IR_W-1:0]        act_ch;
  logic [NCH-1:0]         act_take;
  logic [NCH-1:0]         act_no_take;
  logic                   ir_update;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;
  exp_t sb[$];

  nios_adc_debug_cmd_sysclk #(.SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .vs_udr       (vs_udr),
    .vs_uir       (vs_uir),
    .ir_in        (ir_in),
    .sr           (sr),
    .act_ready    (act_ready),
    .clr_overflow (clr_overflow),
    .act_valid    (act_valid),
    .jdo          (jdo),
    .act_ch       (act_ch),
    .act_take     (act_take),
    .act_no_take  (act_no_take),
    .ir_update    (ir_update),
    .level        (level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One UDR strobe: 3 cycles high, 3 low; optionally records the expectation.
  task automatic udr_pulse(input logic [IR_W-1:0] ch, input logic [SR_W-1:0] d, input bit expect_push);
    exp_t e;
    ir_in = ch;
    sr    = d;
    if (expect_push) begin
      e.ch = ch;
      e.d  = d;
      sb.push_back(e);
    end
    vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
    tick(3);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(act_valid), 64'd0);
    check({tag, "_jdo"}, 64'(jdo), 64'd0);
    check({tag, "_ch"}, 64'(act_ch), 64'd0);
    check({tag, "_take"}, 64'(act_take), 64'd0);
    check({tag, "_notake"}, 64'(act_no_take), 64'd0);
    check({tag, "_level"}, 64'(level), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
    check({tag, "_irupd"}, 64'(ir_update), 64'd0);
  endtask

  // Scoreboard: every accepted handshake must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [NCH-1:0] one;
    if (!reset && act_valid && act_ready) begin
      n_pop++;
      if (sb.size() == 0) begin
        check("pop_unexpected", 64'(act_valid), 64'd0);
      end else begin
        e   = sb.pop_front();
        one = {{(NCH-1){1'b0}}, 1'b1} << e.ch;
        check("pop_jdo", 64'(jdo), 64'(e.d));
        check("pop_ch", 64'(act_ch), 64'(e.ch));
        check("pop_take", 64'(act_take), e.d[SR_W-1] ? 64'(one) : 64'd0);
        check("pop_notake", 64'(act_no_take), e.d[SR_W-1] ? 64'd0 : 64'(one));
      end
    end
  end

  initial begin
    int p0;
    reset        = 1'b1;
    vs_udr       = 1'b0;
    vs_uir       = 1'b0;
    ir_in        = '0;
    sr           = '0;
    act_ready    = 1'b0;
    clr_overflow = 1'b0;
    tick(3);
    check_idle("reset");
    reset = 1'b0;
    tick(2);

    // Single command: latency and decode.
    act_ready = 1'b1;
    ir_in     = 2'd2;
    sr        = 38'h20_0000_00AB;
    sb.push_back('{ch: 2'd2, d: 38'h20_0000_00AB});
    vs_udr    = 1'b1;
    tick(1);
    check("single_e0_valid", 64'(act_valid), 64'd0);
    tick(1);
    check("single_e1_valid", 64'(act_valid), 64'd0);
    tick(1);
    check("single_e2_valid", 64'(act_valid), 64'd1);
    check("single_jdo", 64'(jdo), 64'h20_0000_00AB);
    check("single_ch", 64'(act_ch), 64'd2);
    check("single_take", 64'(act_take), 64'b0100);
    check("single_notake", 64'(act_no_take), 64'd0);
    tick(1);
    vs_udr = 1'b0;
    check("single_after_pop", 64'(act_valid), 64'd0);
    tick(3);

    // Backpressure and overflow.
    act_ready = 1'b0;
    for (int i = 1; i <= 5; i++) udr_pulse(2'd1, 38'(i), i <= 4);
    check("bp_level", 64'(level), 64'd4);
    check("bp_ovf", 64'(overflow), 64'd1);
    act_ready = 1'b1;
    tick(4);
    act_ready = 1'b0;
    check("bp_drained", 64'(level), 64'd0);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);
    check("bp_ovf_hold", 64'(overflow), 64'd1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("bp_ovf_clr", 64'(overflow), 64'd0);

    // Full FIFO with a push coinciding with a pop.
    for (int i = 0; i < 4; i++) udr_pulse(2'd3, 38'h10 + 38'(i), 1'b1);
    check("full_level", 64'(level), 64'd4);
    ir_in  = 2'd0;
    sr     = 38'h20_0000_0014;
    vs_udr = 1'b1;
    tick(2);
    sb.push_back('{ch: 2'd0, d: 38'h20_0000_0014});
    act_ready = 1'b1;
    tick(1);
    act_ready = 1'b0;
    check("fullpop_level", 64'(level), 64'd4);
    check("fullpop_ovf", 64'(overflow), 64'd0);
    vs_udr = 1'b0;
    tick(3);
    act_ready = 1'b1;
    tick(4);
    act_ready = 1'b0;
    check("fullpop_drained", 64'(level), 64'd0);
    check("fullpop_sb_empty", 64'(sb.size()), 64'd0);

    // IR flush.
    for (int i = 0; i < 3; i++) udr_pulse(2'd1, 38'h30 + 38'(i), 1'b1);
    check("flush_pre_level", 64'(level), 64'd3);
    vs_uir = 1'b1;
    tick(2);
    check("flush_e1_irupd", 64'(ir_update), 64'd0);
    tick(1);
    sb.delete();
    check("flush_irupd", 64'(ir_update), 64'd1);
    check("flush_level", 64'(level), 64'd0);
    check("flush_valid", 64'(act_valid), 64'd0);
    tick(1);
    check("flush_irupd_pulse", 64'(ir_update), 64'd0);
    vs_uir = 1'b0;
    tick(3);

    // Same-cycle UIR and UDR: flush then push.
    for (int i = 0; i < 2; i++) udr_pulse(2'd2, 38'h40 + 38'(i), 1'b1);
    ir_in  = 2'd3;
    sr     = 38'h55;
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    tick(3);
    sb.delete();
    sb.push_back('{ch: 2'd3, d: 38'h55});
    check("both_level", 64'(level), 64'd1);
    check("both_irupd", 64'(ir_update), 64'd1);
    check("both_jdo", 64'(jdo), 64'h55);
    check("both_ch", 64'(act_ch), 64'd3);
    check("both_notake", 64'(act_no_take), 64'b1000);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    tick(3);
    act_ready = 1'b1;
    tick(2);
    act_ready = 1'b0;
    check("both_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-operation with UDR held high.
    for (int i = 0; i < 2; i++) udr_pulse(2'd1, 38'h20_0000_0060 + 38'(i), 1'b1);
    ir_in  = 2'd2;
    sr     = 38'h66;
    vs_udr = 1'b1;
    tick(1);
    reset     = 1'b1;
    act_ready = 1'b1;
    tick(1);
    reset = 1'b0;
    sb.delete();
    check_idle("midrst");
    tick(5);
    check("midrst_no_push", 64'(level), 64'd0);
    check("midrst_no_valid", 64'(act_valid), 64'd0);
    vs_udr = 1'b0;
    tick(3);
    udr_pulse(2'd0, 38'h77, 1'b1);
    check("midrst_repush_sb", 64'(sb.size()), 64'd0);
    check("midrst_repush_level", 64'(level), 64'd0);

    // Wrap-around.
    p0 = n_pop;
    for (int i = 0; i < 10; i++) udr_pulse(2'(i), 38'(i), 1'b1);
    act_ready = 1'b0;
    check("wrap_pops", 64'(n_pop - p0), 64'd10);
    check("wrap_sb_empty", 64'(sb.size()), 64'd0);
    check("wrap_ovf", 64'(overflow), 64'd0);
    check("wrap_level", 64'(level), 64'd0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
